mc_datapath_regs: RTL and testbench
===================================

Name: mc_datapath_regs

Overview:
- Non-architectural register and operand-steering stage of the multicycle RV32I core.
- Sits directly downstream of the multicycle control FSM and consumes its control outputs: branch, pc_update, ir_write, result_src, alu_src_a/b, adr_src.
- Holds PC, OldPC, IR, memory data register (MDR), A/B and ALUOut registers.
- Generates the memory address, ALU operands, result bus and extended immediate. ALU and register file are external.

Parameters:
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- branch  in  1  conditional PC write enable (taken when alu_zero=1)
- pc_update  in  1  unconditional PC write enable
- ir_write  in  1  load IR from mem_rdata and OldPC from PC
- adr_src  in  1  memory address select: 0=PC, 1=result
- result_src  in  2  00=ALUOut, 01=MDR, 10=alu_result, 11=0
- alu_src_a  in  2  00=PC, 01=OldPC, 10=A reg, 11=0
- alu_src_b  in  2  00=B reg, 01=imm_ext, 10=32'd4, 11=0
- mem_rdata  in  XLEN  instruction/data read from unified memory
- rf_rd1  in  XLEN  register file read port 1
- rf_rd2  in  XLEN  register file read port 2
- alu_result  in  XLEN  combinational ALU output
- alu_zero  in  1  ALU zero flag
- mem_addr  out  XLEN  unified memory address
- mem_wdata  out  XLEN  store data (B register)
- instr  out  32  IR contents
- op  out  7  instr[6:0], to control FSM
- src_a  out  XLEN  ALU operand A
- src_b  out  XLEN  ALU operand B
- result  out  XLEN  result bus (PC next value, register file write data)
- imm_ext  out  XLEN  sign-extended immediate
- pc  out  XLEN  current PC
- old_pc  out  XLEN  PC of instruction in IR

Behaviour:
- Clock and reset: all registers on posedge clk. reset is synchronous, active-low, and wins over every enable.
- Reset values:
  - pc=RESET_PC, old_pc=0, instr=NOP_INSTR
  - A, B, ALUOut and MDR = 0
  - every output therefore comes out of reset in a defined, non-X state
- PC write: pc_write = pc_update | (branch & alu_zero). When asserted, pc <= result; otherwise PC holds. Both terms set: single write of result.
- IR write: when ir_write=1, instr <= mem_rdata and old_pc <= pc (pre-update value), in the same edge. Otherwise both hold. pc_write and ir_write in the same cycle (fetch) is legal; old_pc captures the old PC.
- Free-running registers (load every cycle, one-cycle latency):
  - A <= rf_rd1
  - B <= rf_rd2
  - ALUOut <= alu_result
  - MDR <= mem_rdata
- Combinational outputs:
  - mem_addr = adr_src ? result : pc
  - mem_wdata = B
  - op = instr[6:0]
  - src_a, src_b and result are muxed per the encodings above; reserved code 11 drives 0.
- Immediate decode from instr opcode:
  - I-type (0010011, 0000011, 1100111): {{20{i[31]}}, i[31:20]}
  - S (0100011): {{20{i[31]}}, i[31:25], i[11:7]}
  - B (1100011): {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0}
  - J (1101111): {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0}
  - U (0110111/0010111): {i[31:12], 12'b0}
  - any other opcode: 0
- Arithmetic: no internal adders; all arithmetic goes through the external ALU. Operand widths are fixed at XLEN with no truncation.
- Required per-state sequences (this block must support them):
  - Fetch: src_a=PC, src_b=4, result=alu_result, pc_update=1, ir_write=1.
  - Decode: ALUOut <= OldPC + imm, i.e. the branch/JAL target.
  - BEQ: A-B through the ALU; a taken branch writes the ALUOut target.
  - JAL: writes the target to PC while computing OldPC+4 into ALUOut.
- Reset mid-instruction: all registers return to reset values on the next edge; the in-flight instruction is discarded.

Decomposition:
- Shared package rv_mc_pkg:
  - opcode localparams
  - RESULT_SRC_*, ALU_SRC_A_*, ALU_SRC_B_* encodings
  - NOP constant
  - the same encodings are used by the control FSM
- One sub-module: imm_gen, a combinational immediate extender taking instr and producing imm_ext.

Test Plan:
- Reset with reset=0 for 2 cycles -> pc=0, instr=32'h13, old_pc=0, src_a=0 (PC), mem_addr=0.
- Fetch: pc=0x100, mem_rdata=0x00500093, alu_result=0x104, pc_update=ir_write=1, alu_src_a=00, alu_src_b=10, result_src=10 -> next edge pc=0x104, old_pc=0x100, instr=0x00500093, imm_ext=5, op=0010011.
- Branch taken: ALUOut=0x200, branch=1, alu_zero=1, result_src=00 -> pc=0x200. Same with alu_zero=0 -> pc unchanged.
- B-immediate: instr=0xFE000EE3 (beq x0,x0,-4) -> imm_ext=0xFFFF_FFFC. With old_pc=0x10, alu_src_a=01, alu_src_b=01 -> src_a=0x10, src_b=0xFFFF_FFFC.
- Load path: adr_src=1, result_src=00, ALUOut=0x40 -> mem_addr=0x40. Next cycle mem_rdata=0xDEADBEEF, result_src=01 -> result=0xDEADBEEF.
- Reset while pc_update=1 and ir_write=1 -> reset values win: pc=RESET_PC, instr=NOP.

Source files
------------

// File: rtl/rv_mc_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, operand/result
// select codes and the reset instruction, common to the control FSM and datapath.
package rv_mc_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] RESULT_SRC_ALUOUT = 2'b00;
   localparam logic [1:0] RESULT_SRC_MDR    = 2'b01;
   localparam logic [1:0] RESULT_SRC_ALU    = 2'b10;
   localparam logic [1:0] RESULT_SRC_ZERO   = 2'b11;

   localparam logic [1:0] ALU_SRC_A_PC     = 2'b00;
   localparam logic [1:0] ALU_SRC_A_OLDPC  = 2'b01;
   localparam logic [1:0] ALU_SRC_A_REG    = 2'b10;
   localparam logic [1:0] ALU_SRC_A_ZERO   = 2'b11;

   localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
   localparam logic [1:0] ALU_SRC_B_IMM    = 2'b01;
   localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b10;
   localparam logic [1:0] ALU_SRC_B_ZERO   = 2'b11;

   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

endpackage

// File: rtl/mc_datapath_regs_imm_gen.sv
// Combinational immediate extender: decodes the instruction format from the
// opcode and produces the sign-extended immediate (zero for formats without one).
module imm_gen
   import rv_mc_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm_ext
);

   always_comb begin
      imm_ext = 32'h0000_0000;
      case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm_ext = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_JAL:
            imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm_ext = {instr[31:12], 12'h000};
         default:
            imm_ext = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mc_datapath_regs.sv
// Non-architectural registers and operand steering of the multicycle RV32I core:
// PC/OldPC/IR/MDR/A/B/ALUOut plus memory-address, ALU-operand and result muxes.
module mc_datapath_regs
   import rv_mc_pkg::*;
#(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]      NOP_INSTR = NOP_INSTR_C
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            branch,
   input  logic            pc_update,
   input  logic            ir_write,
   input  logic            adr_src,
   input  logic [1:0]      result_src,
   input  logic [1:0]      alu_src_a,
   input  logic [1:0]      alu_src_b,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [XLEN-1:0] rf_rd1,
   input  logic [XLEN-1:0] rf_rd2,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [31:0]     instr,
   output logic [6:0]      op,
   output logic [XLEN-1:0] src_a,
   output logic [XLEN-1:0] src_b,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] imm_ext,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] old_pc
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] old_pc_q, old_pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] alu_out_q, alu_out_d;
   logic [XLEN-1:0] mdr_q, mdr_d;
   logic [31:0]     imm32;
   logic            pc_write;

   imm_gen u_imm_gen (
      .instr   (instr_q),
      .imm_ext (imm32)
   );

   assign pc_write = pc_update | (branch & alu_zero);

   always_comb begin
      result = '0;
      case (result_src)
         RESULT_SRC_ALUOUT: result = alu_out_q;
         RESULT_SRC_MDR:    result = mdr_q;
         RESULT_SRC_ALU:    result = alu_result;
         default:           result = '0;
      endcase
   end

   always_comb begin
      src_a = '0;
      case (alu_src_a)
         ALU_SRC_A_PC:    src_a = pc_q;
         ALU_SRC_A_OLDPC: src_a = old_pc_q;
         ALU_SRC_A_REG:   src_a = a_q;
         default:         src_a = '0;
      endcase
   end

   always_comb begin
      src_b = '0;
      case (alu_src_b)
         ALU_SRC_B_REG:  src_b = b_q;
         ALU_SRC_B_IMM:  src_b = imm_ext;
         ALU_SRC_B_FOUR: src_b = XLEN'(32'd4);
         default:        src_b = '0;
      endcase
   end

   // Reset dominates all enables; old_pc captures the pre-update PC on a fetch.
   always_comb begin
      pc_d      = pc_q;
      old_pc_d  = old_pc_q;
      instr_d   = instr_q;
      a_d       = rf_rd1;
      b_d       = rf_rd2;
      alu_out_d = alu_result;
      mdr_d     = mem_rdata;
      if (!reset) begin
         pc_d      = RESET_PC;
         old_pc_d  = '0;
         instr_d   = NOP_INSTR;
         a_d       = '0;
         b_d       = '0;
         alu_out_d = '0;
         mdr_d     = '0;
      end else begin
         if (pc_write) begin
            pc_d = result;
         end else begin
            pc_d = pc_q;
         end
         if (ir_write) begin
            instr_d  = mem_rdata[31:0];
            old_pc_d = pc_q;
         end else begin
            instr_d  = instr_q;
            old_pc_d = old_pc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
   end

   assign imm_ext   = XLEN'($signed(imm32));
   assign mem_addr  = adr_src ? result : pc_q;
   assign mem_wdata = b_q;
   assign instr     = instr_q;
   assign op        = instr_q[6:0];
   assign pc        = pc_q;
   assign old_pc    = old_pc_q;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Self-checking bench for mc_datapath_regs: directed vector table for the
// fetch/branch/load/reset sequences, then randomized traffic against a reference model.
module tb_mc_datapath_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic        branch, pc_update, ir_write, adr_src, alu_zero;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic [31:0] mem_rdata, rf_rd1, rf_rd2, alu_result;
   logic [31:0] mem_addr, mem_wdata, instr, src_a, src_b, result, imm_ext, pc, old_pc;
   logic [6:0]  op;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_datapath_regs dut (
      .clk(clk), .reset(reset), .branch(branch), .pc_update(pc_update),
      .ir_write(ir_write), .adr_src(adr_src), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_rdata(mem_rdata),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .alu_result(alu_result), .alu_zero(alu_zero),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .instr(instr), .op(op),
      .src_a(src_a), .src_b(src_b), .result(result), .imm_ext(imm_ext),
      .pc(pc), .old_pc(old_pc)
   );

   typedef struct {
      logic        rst_n, br, pcu, irw, adr;
      logic [1:0]  rs, sa, sb;
      logic [31:0] rdata, alu_res;
      logic        zero, chk_pre;
      logic [31:0] e_res, e_sa, e_sb, e_addr;
      logic [31:0] e_pc, e_old, e_instr, e_imm;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] m_pc, m_old, m_instr, m_a, m_b, m_aluout, m_mdr;

   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: return 32'($signed(i[31:20]));
         7'b0100011: return 32'($signed({i[31:25], i[11:7]}));
         7'b1100011: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         7'b1101111: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         7'b0110111, 7'b0010111: return {i[31:12], 12'h000};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_result();
      case (result_src)
         2'd0: return m_aluout;
         2'd1: return m_mdr;
         2'd2: return alu_result;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_src_a();
      case (alu_src_a)
         2'd0: return m_pc;
         2'd1: return m_old;
         2'd2: return m_a;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_src_b();
      case (alu_src_b)
         2'd0: return m_b;
         2'd1: return ref_imm(m_instr);
         2'd2: return 32'd4;
         default: return 32'h0;
      endcase
   endfunction

   task automatic set_idle();
      reset = 1'b1; branch = 1'b0; pc_update = 1'b0; ir_write = 1'b0; adr_src = 1'b0;
      result_src = 2'd0; alu_src_a = 2'd0; alu_src_b = 2'd0; alu_zero = 1'b0;
      mem_rdata = 32'h0; rf_rd1 = 32'h0; rf_rd2 = 32'h0; alu_result = 32'h0;
   endtask

   logic [6:0] opcs[10];

   initial begin
      set_idle();
      reset = 1'b0;

      //         rst br pcu irw adr rs    sa    sb    rdata         alu_res       z  pre   e_res         e_sa          e_sb          e_addr        e_pc          e_old         e_instr       e_imm
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,32'h0,       32'h0,       1'b0,1'b0,32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h13,      32'h0};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,32'h0,       32'h0,       1'b0,1'b1,32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h13,      32'h0};
      vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,2'd2,2'd0,2'd0,32'h0,       32'h100,     1'b0,1'b1,32'h100,     32'h0,       32'h0,       32'h0,       32'h100,     32'h0,       32'h13,      32'h0};
      vecs[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,2'd2,2'd0,2'd2,32'h00500093,32'h104,     1'b0,1'b1,32'h104,     32'h100,     32'h4,       32'h100,     32'h104,     32'h100,     32'h00500093,32'h5};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,32'h0,       32'h200,     1'b0,1'b1,32'h200,     32'h104,     32'h0,       32'h104,     32'h104,     32'h100,     32'h00500093,32'h5};
      vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,32'h0,       32'h999,     1'b1,1'b1,32'h200,     32'h104,     32'h0,       32'h104,     32'h200,     32'h100,     32'h00500093,32'h5};
      vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,32'h0,       32'h300,     1'b0,1'b1,32'h999,     32'h200,     32'h0,       32'h200,     32'h200,     32'h100,     32'h00500093,32'h5};
      vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,2'd2,2'd0,2'd0,32'h0,       32'h10,      1'b0,1'b1,32'h10,      32'h200,     32'h0,       32'h200,     32'h10,      32'h100,     32'h00500093,32'h5};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,2'd2,2'd0,2'd0,32'hFE000EE3,32'h40,      1'b0,1'b1,32'h40,      32'h10,      32'h0,       32'h10,      32'h10,      32'h10,      32'hFE000EE3,32'hFFFFFFFC};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,2'd1,32'hDEADBEEF,32'h0,       1'b0,1'b1,32'h40,      32'h10,      32'hFFFFFFFC,32'h40,      32'h10,      32'h10,      32'hFE000EE3,32'hFFFFFFFC};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,32'h0,       32'h0,       1'b0,1'b1,32'hDEADBEEF,32'h10,      32'h0,       32'h10,      32'h10,      32'h10,      32'hFE000EE3,32'hFFFFFFFC};
      vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,2'd2,2'd0,2'd0,32'h12345678,32'h500,     1'b0,1'b1,32'h500,     32'h10,      32'h0,       32'h10,      32'h0,       32'h0,       32'h13,      32'h0};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,2'd3,2'd3,2'd3,32'h0,       32'h0,       1'b0,1'b1,32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h13,      32'h0};

      @(posedge clk); #1;
      for (int i = 0; i < 13; i++) begin
         reset = vecs[i].rst_n; branch = vecs[i].br; pc_update = vecs[i].pcu;
         ir_write = vecs[i].irw; adr_src = vecs[i].adr; result_src = vecs[i].rs;
         alu_src_a = vecs[i].sa; alu_src_b = vecs[i].sb; mem_rdata = vecs[i].rdata;
         alu_result = vecs[i].alu_res; alu_zero = vecs[i].zero;
         #1;
         if (vecs[i].chk_pre) begin
            chk($sformatf("v%0d result", i), result, vecs[i].e_res);
            chk($sformatf("v%0d src_a", i), src_a, vecs[i].e_sa);
            chk($sformatf("v%0d src_b", i), src_b, vecs[i].e_sb);
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d old_pc", i), old_pc, vecs[i].e_old);
         chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
         chk($sformatf("v%0d imm_ext", i), imm_ext, vecs[i].e_imm);
         chk($sformatf("v%0d op", i), {25'h0, op}, {25'h0, vecs[i].e_instr[6:0]});
      end

      // Model starts from the state left by the last table row (all inputs zero).
      m_pc = 32'h0; m_old = 32'h0; m_instr = 32'h13;
      m_a = 32'h0; m_b = 32'h0; m_aluout = 32'h0; m_mdr = 32'h0;
      opcs = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
               7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1111111};

      for (int c = 0; c < 400; c++) begin
         logic [31:0] nres;
         reset      = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
         branch     = 1'($urandom);
         pc_update  = ($urandom_range(0, 3) == 0);
         ir_write   = ($urandom_range(0, 2) == 0);
         adr_src    = 1'($urandom);
         alu_zero   = 1'($urandom);
         result_src = 2'($urandom);
         alu_src_a  = 2'($urandom);
         alu_src_b  = 2'($urandom);
         mem_rdata  = {$urandom()} & 32'hFFFF_FF80;
         mem_rdata[6:0] = opcs[$urandom_range(0, 9)];
         rf_rd1     = $urandom();
         rf_rd2     = $urandom();
         alu_result = $urandom();
         #1;
         nres = ref_result();
         chk("rnd result", result, nres);
         chk("rnd src_a", src_a, ref_src_a());
         chk("rnd src_b", src_b, ref_src_b());
         chk("rnd mem_addr", mem_addr, adr_src ? nres : m_pc);
         chk("rnd mem_wdata", mem_wdata, m_b);
         chk("rnd imm_ext", imm_ext, ref_imm(m_instr));
         chk("rnd op", {25'h0, op}, {25'h0, m_instr[6:0]});
         if (!reset) begin
            m_pc = 32'h0; m_old = 32'h0; m_instr = 32'h13;
            m_a = 32'h0; m_b = 32'h0; m_aluout = 32'h0; m_mdr = 32'h0;
         end else begin
            if (ir_write) begin
               m_old = m_pc;
               m_instr = mem_rdata;
            end
            if (pc_update || (branch && alu_zero)) m_pc = nres;
            m_a = rf_rd1; m_b = rf_rd2; m_aluout = alu_result; m_mdr = mem_rdata;
         end
         @(posedge clk); #1;
         chk("rnd pc", pc, m_pc);
         chk("rnd old_pc", old_pc, m_old);
         chk("rnd instr", instr, m_instr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
